// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction memory controller: FSM encodings,
// fault response data and the address-span helper.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StRead = 2'd2,
        StResp = 2'd3
    } imem_state_e;

    localparam logic [31:0] FAULT_DATA = 32'h0000_0000;

    // Byte span covered by 2^depth_log2 words, kept at 64 bits so range checks never truncate.
    function automatic logic [63:0] span_bytes(input int unsigned depth_log2);
        return 64'd4 << depth_log2;
    endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Fetch and SRAM signal bundle for imem_ctrl; slave is the controller side,
// master is the IFU/SRAM environment side.
interface imem_ctrl_if #(
    parameter int unsigned DEPTH_LOG2 = 16
);
    logic [63:0]           ifu_memory_addr;
    logic                  ifu_memory_valid;
    logic [31:0]           memory_ifu_data;
    logic                  memory_ifu_valid;
    logic                  imem_err;
    logic [DEPTH_LOG2-1:0] sram_addr;
    logic                  sram_ren;
    logic [31:0]           sram_rdata;

    modport slave (
        input  ifu_memory_addr,
        input  ifu_memory_valid,
        input  sram_rdata,
        output memory_ifu_data,
        output memory_ifu_valid,
        output imem_err,
        output sram_addr,
        output sram_ren
    );

    modport master (
        output ifu_memory_addr,
        output ifu_memory_valid,
        output sram_rdata,
        input  memory_ifu_data,
        input  memory_ifu_valid,
        input  imem_err,
        input  sram_addr,
        input  sram_ren
    );
endinterface

// File: rtl/imem_hit_buf.sv
// One-entry buffer holding the word address and data of the last good SRAM response.
module imem_hit_buf (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        i_wr_en,
    input  logic [61:0] i_wr_waddr,
    input  logic [31:0] i_wr_data,
    input  logic [63:0] i_lookup_addr,
    output logic        o_hit,
    output logic [31:0] o_data
);
    logic        r_valid;
    logic [61:0] r_waddr;
    logic [31:0] r_data;

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_valid <= 1'b0;
            r_waddr <= '0;
            r_data  <= '0;
        end else if (i_wr_en) begin
            r_valid <= 1'b1;
            r_waddr <= i_wr_waddr;
            r_data  <= i_wr_data;
        end
    end

    // A misaligned lookup must still take the fault path, so it never hits.
    assign o_hit  = r_valid && (i_lookup_addr[63:2] == r_waddr) && (i_lookup_addr[1:0] == 2'b00);
    assign o_data = r_data;
endmodule

// File: rtl/imem_ctrl.sv
// Instruction fetch controller with programmable wait states in front of a word SRAM.
// Defining IMEM_LAST_HIT_EN adds a one-entry last-hit buffer that bypasses the SRAM.
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [63:0] ADDR_BASE   = 64'h8000_0000,
    parameter int unsigned DEPTH_LOG2  = 16
) (
    input logic        core_clk,
    input logic        core_rst,
    imem_ctrl_if.slave bus
);
    localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);
    localparam logic [63:0] LP_SPAN = span_bytes(DEPTH_LOG2);

    imem_state_e r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [63:0] r_addr, w_addr_nxt;
    logic [31:0] r_data, w_data_nxt;

    logic [63:0]           w_off;
    logic                  w_fault;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_sram_ren;
    logic [DEPTH_LOG2-1:0] w_sram_addr;
    logic                  w_rsp_valid;
    logic                  w_rsp_err;
    logic [31:0]           w_rsp_data;

    assign w_off   = r_addr - ADDR_BASE;
    assign w_fault = (r_addr[1:0] != 2'b00) || (r_addr < ADDR_BASE) || (w_off >= LP_SPAN);
    assign w_idx   = w_off[DEPTH_LOG2+1:2];

`ifdef IMEM_LAST_HIT_EN
    logic        r_hit, w_hit_nxt;
    logic        w_buf_hit;
    logic        w_buf_wr;
    logic [31:0] w_buf_data;

    imem_hit_buf u_hit_buf (
        .core_clk      (core_clk),
        .core_rst      (core_rst),
        .i_wr_en       (w_buf_wr),
        .i_wr_waddr    (r_addr[63:2]),
        .i_wr_data     (bus.sram_rdata),
        .i_lookup_addr (bus.ifu_memory_addr),
        .o_hit         (w_buf_hit),
        .o_data        (w_buf_data)
    );
`endif

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
`ifdef IMEM_LAST_HIT_EN
            r_hit   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
`ifdef IMEM_LAST_HIT_EN
            r_hit   <= w_hit_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_sram_ren  = 1'b0;
        w_sram_addr = '0;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_data  = r_data;
`ifdef IMEM_LAST_HIT_EN
        w_hit_nxt   = r_hit;
        w_buf_wr    = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (bus.ifu_memory_valid) begin
                    w_addr_nxt  = bus.ifu_memory_addr;
                    w_cnt_nxt   = LP_WAIT;
                    // Zero wait states go straight to the read to keep latency at WAIT_CYCLES+2.
                    w_state_nxt = (LP_WAIT == 4'd0) ? StRead : StWait;
`ifdef IMEM_LAST_HIT_EN
                    w_hit_nxt = w_buf_hit;
                    if (w_buf_hit) begin
                        w_state_nxt = StResp;
                    end
`endif
                end
            end
            StWait: begin
                if (!bus.ifu_memory_valid) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = StRead;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            StRead: begin
                if (!bus.ifu_memory_valid) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_state_nxt = StResp;
                    w_sram_ren  = !w_fault;
                    w_sram_addr = w_fault ? '0 : w_idx;
                end
            end
            StResp: begin
                w_state_nxt = StIdle;
                w_rsp_valid = 1'b1;
                w_rsp_err   = w_fault;
                w_rsp_data  = w_fault ? FAULT_DATA : bus.sram_rdata;
`ifdef IMEM_LAST_HIT_EN
                if (r_hit) begin
                    w_rsp_err  = 1'b0;
                    w_rsp_data = w_buf_data;
                end
                w_buf_wr = !w_fault && !r_hit;
`endif
                w_data_nxt = w_rsp_data;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign bus.memory_ifu_data  = w_rsp_data;
    assign bus.memory_ifu_valid = w_rsp_valid;
    assign bus.imem_err         = w_rsp_err;
    assign bus.sram_ren         = w_sram_ren;
    assign bus.sram_addr        = w_sram_addr;
endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: table-driven fetches plus reset and refetch sequences.
module tb_imem_ctrl;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    imem_ctrl_if #(.DEPTH_LOG2(16)) bus ();

    imem_ctrl #(
        .WAIT_CYCLES (2),
        .ADDR_BASE   (64'h8000_0000),
        .DEPTH_LOG2  (16)
    ) u_dut (
        .core_clk (clk),
        .core_rst (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] idx);
        return (idx == 16'd0) ? 32'h0000_0513 : {16'hC0DE, idx};
    endfunction

    // SRAM model: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (bus.sram_ren) bus.sram_rdata <= mem_word(bus.sram_addr);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [63:0] addr2;
        int          drop;
        bit          restart;
        int          ren_cnt;
        int          ren_cyc;
        logic [15:0] idx;
        int          vld_cnt;
        int          vld_cyc;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs[11];

    // Drives one request at cycle 0 (entered #1 after a posedge), addr2 from cycle 1 on.
    task automatic run_fetch(input vec_t v, output int ren_cnt, output int ren_cyc,
                             output logic [15:0] ren_idx, output int vld_cnt,
                             output int vld_cyc, output logic [31:0] data,
                             output logic err, output logic [31:0] hold);
        bit got;
        got = 0; ren_cnt = 0; ren_cyc = -1; ren_idx = '0;
        vld_cnt = 0; vld_cyc = -1; data = '0; err = 1'b0;
        for (int c = 0; c < 14; c++) begin
            bus.ifu_memory_addr  = (c == 0) ? v.addr : v.addr2;
            bus.ifu_memory_valid = !got &&
                !(v.drop >= 0 && c >= v.drop && !(v.restart && c > v.drop));
            @(negedge clk);
            if (bus.sram_ren) begin
                ren_cnt++; ren_cyc = c; ren_idx = bus.sram_addr;
            end
            if (bus.memory_ifu_valid) begin
                vld_cnt++; vld_cyc = c; data = bus.memory_ifu_data; err = bus.imem_err;
                got = 1;
            end
            @(posedge clk); #1;
        end
        bus.ifu_memory_valid = 1'b0;
        hold = bus.memory_ifu_data;
    endtask

    initial begin
        int          ren_cnt, ren_cyc, vld_cnt, vld_cyc;
        logic [15:0] ren_idx;
        logic [31:0] data, hold, last_data;
        logic        err;
        int          v1, v2, rc, nv;
        logic [31:0] d1, d2;

        n_total = 0;
        n_pass  = 0;
        last_data = 32'h0;
        //            addr                   addr2                 drop rs ren cyc idx    vld cyc data          err
        vecs[0]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0100, -1, 0, 1, 3, 16'h0000, 1, 4, 32'h0000_0513, 1'b0};
        vecs[1]  = '{64'h0000_0000_8000_0004, 64'h0000_0000_8000_0000, -1, 0, 1, 3, 16'h0001, 1, 4, 32'hC0DE_0001, 1'b0};
        vecs[2]  = '{64'h0000_0000_8003_FFFC, 64'h0000_0000_8000_0000, -1, 0, 1, 3, 16'hFFFF, 1, 4, 32'hC0DE_FFFF, 1'b0};
        vecs[3]  = '{64'h0000_0000_8004_0000, 64'h0000_0000_8000_0000, -1, 0, 0, 0, 16'h0000, 1, 4, 32'h0000_0000, 1'b1};
        vecs[4]  = '{64'h0000_0000_8000_0002, 64'h0000_0000_8000_0004, -1, 0, 0, 0, 16'h0000, 1, 4, 32'h0000_0000, 1'b1};
        vecs[5]  = '{64'h0000_0000_7FFF_FFFC, 64'h0000_0000_8000_0004, -1, 0, 0, 0, 16'h0000, 1, 4, 32'h0000_0000, 1'b1};
        vecs[6]  = '{64'h0000_0001_8000_0000, 64'h0000_0000_8000_0004, -1, 0, 0, 0, 16'h0000, 1, 4, 32'h0000_0000, 1'b1};
        vecs[7]  = '{64'h0000_0000_8000_1234, 64'h0000_0000_8000_0010, -1, 0, 1, 3, 16'h048D, 1, 4, 32'hC0DE_048D, 1'b0};
        vecs[8]  = '{64'h0000_0000_8000_0008, 64'h0000_0000_8000_0010,  2, 0, 0, 0, 16'h0000, 0, 0, 32'h0000_0000, 1'b0};
        vecs[9]  = '{64'h0000_0000_8000_0008, 64'h0000_0000_8000_0010,  3, 0, 0, 0, 16'h0000, 0, 0, 32'h0000_0000, 1'b0};
        vecs[10] = '{64'h0000_0000_8000_0008, 64'h0000_0000_8000_000C,  2, 1, 1, 6, 16'h0003, 1, 7, 32'hC0DE_0003, 1'b0};

        rst = 1'b1;
        bus.ifu_memory_valid = 1'b0;
        bus.ifu_memory_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset valid", 64'(bus.memory_ifu_valid), 64'd0);
        check("reset data", 64'(bus.memory_ifu_data), 64'd0);
        check("reset err", 64'(bus.imem_err), 64'd0);
        check("reset sram_ren", 64'(bus.sram_ren), 64'd0);
        check("reset sram_addr", 64'(bus.sram_addr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_fetch(vecs[i], ren_cnt, ren_cyc, ren_idx, vld_cnt, vld_cyc, data, err, hold);
            check($sformatf("v%0d ren_cnt", i), 64'(ren_cnt), 64'(vecs[i].ren_cnt));
            if (vecs[i].ren_cnt > 0) begin
                check($sformatf("v%0d ren_cyc", i), 64'(ren_cyc), 64'(vecs[i].ren_cyc));
                check($sformatf("v%0d sram_addr", i), 64'(ren_idx), 64'(vecs[i].idx));
            end
            check($sformatf("v%0d vld_cnt", i), 64'(vld_cnt), 64'(vecs[i].vld_cnt));
            if (vecs[i].vld_cnt > 0) begin
                check($sformatf("v%0d vld_cyc", i), 64'(vld_cyc), 64'(vecs[i].vld_cyc));
                check($sformatf("v%0d data", i), 64'(data), 64'(vecs[i].data));
                check($sformatf("v%0d err", i), 64'(err), 64'(vecs[i].err));
                last_data = vecs[i].data;
            end
            check($sformatf("v%0d hold", i), 64'(hold), 64'(last_data));
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset in the READ cycle drops the fetch and clears every output.
        bus.ifu_memory_addr  = 64'h8000_0004;
        bus.ifu_memory_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.ifu_memory_valid = 1'b0;
        @(negedge clk);
        check("midrst valid", 64'(bus.memory_ifu_valid), 64'd0);
        check("midrst data", 64'(bus.memory_ifu_data), 64'd0);
        check("midrst err", 64'(bus.imem_err), 64'd0);
        check("midrst sram_ren", 64'(bus.sram_ren), 64'd0);
        check("midrst sram_addr", 64'(bus.sram_addr), 64'd0);
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.memory_ifu_valid || bus.sram_ren) nv++;
        end
        check("midrst no response", 64'(nv), 64'd0);
        @(posedge clk); #1;

        // Request held through the first response: RESP must not re-accept.
        v1 = -1; v2 = -1; rc = 0; nv = 0; d1 = '0; d2 = '0;
        for (int c = 0; c < 16; c++) begin
            bus.ifu_memory_addr  = 64'h8000_0000;
            bus.ifu_memory_valid = (nv < 2);
            @(negedge clk);
            if (bus.sram_ren) rc++;
            if (bus.memory_ifu_valid) begin
                nv++;
                if (nv == 1) begin v1 = c; d1 = bus.memory_ifu_data; end
                if (nv == 2) begin v2 = c; d2 = bus.memory_ifu_data; end
            end
            @(posedge clk); #1;
        end
        bus.ifu_memory_valid = 1'b0;
        check("refetch first vld", 64'(v1), 64'd4);
        check("refetch first data", 64'(d1), 64'h0000_0513);
        check("refetch second data", 64'(d2), 64'h0000_0513);
`ifdef IMEM_LAST_HIT_EN
        check("refetch second vld", 64'(v2), 64'd6);
        check("refetch ren count", 64'(rc), 64'd1);
`else
        check("refetch second vld", 64'(v2), 64'd9);
        check("refetch ren count", 64'(rc), 64'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 2: extra wait states before each SRAM read, range 0..15.
REQ-002 SHALL provide parameter ADDR_BASE, default 64'h8000_0000: byte address of word 0.
REQ-003 SHALL provide parameter DEPTH_LOG2, default 16: SRAM holds 2^DEPTH_LOG2 32-bit words.
REQ-004 SHALL have one clock and one reset: synchronous, active-high; no other clock or reset.
REQ-005 SHALL have core_clk  input  1: sole clock, rising edge.
REQ-006 SHALL have core_rst  input  1: synchronous active-high reset.
REQ-007 SHALL have ifu_memory_addr  input  64: fetch byte address, from IFU.
REQ-008 SHALL have ifu_memory_valid  input  1: fetch request level, from IFU.
REQ-009 SHALL have memory_ifu_data  output  32: instruction word, to IFU.
REQ-010 SHALL have memory_ifu_valid  output  1: one-cycle response strobe, to IFU.
REQ-011 SHALL have imem_err  output  1: pulses together with memory_ifu_valid on a faulting fetch.
REQ-012 SHALL have sram_addr  output  DEPTH_LOG2: SRAM word index.
REQ-013 SHALL have sram_ren  output  1: SRAM read enable.
REQ-014 SHALL have sram_rdata  input  32: SRAM data, valid the cycle after sram_ren.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, READ, RESP.
- IDLE->WAIT on ifu_memory_valid.
- WAIT->READ when the wait counter reaches 0.
- READ->RESP always.
- RESP->IDLE always.
REQ-016 SHALL latch ifu_memory_addr on the IDLE->WAIT transition and load the wait counter with WAIT_CYCLES; WAIT SHALL last exactly WAIT_CYCLES cycles (0 = a single pass-through cycle).
REQ-017 SHALL assert sram_ren for exactly one cycle in READ, with sram_addr = (latched addr - ADDR_BASE)[DEPTH_LOG2+1:2]; sram_ren SHALL be 0 in all other states.
REQ-018 SHALL, in RESP, drive memory_ifu_valid=1 for one cycle with memory_ifu_data=sram_rdata; outside RESP, memory_ifu_valid=0 and memory_ifu_data holds its last value.
REQ-019 SHALL give request accepted at cycle T -> memory_ifu_valid at T+WAIT_CYCLES+2.
REQ-020 SHALL treat a latched addr with addr[1:0]!=0, addr<ADDR_BASE, or addr>=ADDR_BASE+4*2^DEPTH_LOG2 as a fault: same state sequence and latency, sram_ren suppressed, memory_ifu_data=32'h0, imem_err=1 in RESP.
REQ-021 SHALL abort to IDLE with no response and no sram_ren if ifu_memory_valid drops in WAIT or READ; changes to ifu_memory_addr during WAIT/READ SHALL be ignored.
REQ-022 SHALL NOT accept a request in RESP; a request still present after RESP is accepted in the following IDLE cycle.
REQ-023 SHALL compute the address subtraction in 64 bits; the range check uses no truncation.

Reset
REQ-024 SHALL, on core_rst at any cycle (including mid-operation), clear the following at the next edge, dropping any in-flight fetch:
- state=IDLE, wait counter=0, latched addr=0;
- memory_ifu_valid=0, memory_ifu_data=0, imem_err=0;
- sram_ren=0, sram_addr=0.

Configuration
REQ-025 SHALL support macro IMEM_LAST_HIT_EN.
- Defined: a one-entry buffer holds {valid, word addr, data} of the last non-faulting response. An IDLE request whose word addr matches a valid entry goes IDLE->RESP directly (valid at T+1, no sram_ren). The entry is refreshed on every SRAM response and cleared by reset.
- Undefined: no buffer; every fetch takes the full path.

Structure
REQ-026 SHALL place the FSM state encodings and the fault data value 32'h0 in the shared defines include.
REQ-027 SHALL implement the hit buffer as sub-module imem_hit_buf, instantiated only under IMEM_LAST_HIT_EN.

Verification
REQ-028 WAIT_CYCLES=2, addr 0x8000_0000 held valid at T, SRAM word0=0x0000_0513 -> sram_ren at T+3, valid with data 0x0000_0513 at T+4, imem_err=0.
REQ-029 addr 0x8000_0002 -> no sram_ren, valid at T+4 with data 0, imem_err=1; addr 0x7FFF_FFFC -> same.
REQ-030 ifu_memory_valid dropped at T+2 -> no sram_ren, no valid; new request at T+3 is served at T+7.
REQ-031 core_rst asserted at T+3 -> all outputs 0 at T+4, state IDLE, no response.
REQ-032 With IMEM_LAST_HIT_EN, refetch of 0x8000_0000 right after its response -> valid at T+1, data 0x0000_0513, sram_ren never asserted; without the macro -> T+4.
